// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates load-use stalls,
// branch flushes and multi-cycle data-memory accesses, with a wait watchdog.
module pipeline_stall_controller #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hazard_i,
  input  logic        branch_i,
  input  logic        mem_access_i,
  input  logic        mem_ack_i,
  output logic        pc_stall_o,
  output logic        ifid_stall_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        freeze_o,
  output logic        mem_req_o,
  output logic        timeout_o,
  output logic [15:0] stall_cnt_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic pc_stall, ifid_stall, ifid_flush, idex_bubble, freeze;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    freeze      = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_access_i) begin
          freeze     = 1'b1;
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd0;
        end else begin
          // A branch under a load-use stall is re-presented next cycle.
          pc_stall    = hazard_i;
          ifid_stall  = hazard_i;
          idex_bubble = hazard_i;
          ifid_flush  = branch_i & ~hazard_i;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack_i) begin
          pc_stall    = hazard_i;
          ifid_stall  = hazard_i;
          idex_bubble = hazard_i;
          ifid_flush  = branch_i & ~hazard_i;
          state_d     = ST_RUN;
          wait_cnt_d  = 8'd0;
        end else begin
          freeze     = 1'b1;
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q + 8'd1 >= TIMEOUT_C) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        freeze     = 1'b1;
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase

    // Outputs stay quiet while reset is held.
    if (rst_i) begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      freeze      = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_stall_o    = pc_stall;
  assign ifid_stall_o  = ifid_stall;
  assign ifid_flush_o  = ifid_flush;
  assign idex_bubble_o = idex_bubble;
  assign freeze_o      = freeze;
  assign mem_req_o     = (state_q == ST_MEM_WAIT);
  assign timeout_o     = (state_q == ST_ERROR);
  assign stall_cnt_o   = stall_cnt_q;
  assign state_o       = state_q;

endmodule
